bitty_sequencer: RTL and testbench
==================================

Name: bitty_sequencer

Overview:
Program loader and execution sequencer for the bitty core inside the tt_um_bitty top level. It assembles 16-bit instructions from a byte stream (UART receive side) into a small local instruction memory. On a start pulse it issues the instructions to the core one at a time: run/done handshake, branch-aware PC update. After each instruction it streams the 16-bit core result out as two bytes over a ready/valid transmit interface.

Parameters:
MEM_DEPTH, 16, number of 16-bit instruction words stored
ADDR_W, 4, PC/address width; must equal clog2(MEM_DEPTH)
TIMEOUT, 255, max cycles to wait for core_done before flagging error

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
load_en  input  1  level; 1 = byte stream writes program memory
rx_valid  input  1  one-cycle strobe, rx_data valid
rx_data  input  8  received byte
start  input  1  one-cycle pulse, begin execution at PC 0
abort  input  1  one-cycle pulse, stop execution, return to IDLE
instr_out  output  16  instruction presented to core
core_run  output  1  one-cycle pulse, core executes instr_out
core_done  input  1  one-cycle pulse, core finished
core_result  input  16  core result, valid with core_done
branch_taken  input  1  valid with core_done
branch_target  input  ADDR_W  valid with core_done
tx_valid  output  1  tx_data valid
tx_data  output  8  byte to transmit
tx_ready  input  1  transmitter accepts byte when tx_valid & tx_ready
busy  output  1  high in any state but IDLE
run_done  output  1  one-cycle pulse, program completed normally
error  output  1  sticky; load overflow or core timeout

Behaviour:
- Reset (async, immediate): state IDLE, pc=0, instr_count=0, byte_phase=0, instr_out=0, core_run=0, tx_valid=0, tx_data=0, run_done=0, error=0. Memory contents are not reset.
- Loading happens in IDLE with load_en=1. On rx_valid the first byte is the high byte (held) and the second is the low byte. The word then writes to mem[instr_count] and instr_count increments.
- The rising edge of load_en clears instr_count and byte_phase (new program).
- An rx_valid arriving when instr_count==MEM_DEPTH sets error; the byte is dropped and instr_count saturates.
- rx_valid with load_en=0, or outside IDLE, is ignored.
- start is ignored unless in IDLE with load_en=0. If instr_count==0, run_done pulses the next cycle and the state stays IDLE.
- States: IDLE -> ISSUE -> WAIT -> SEND_HI -> SEND_LO -> (ISSUE | FINISH) -> IDLE.
- ISSUE (1 cycle): instr_out<=mem[pc], core_run=1 for exactly this cycle, then WAIT. instr_out holds until the next ISSUE.
- WAIT: timeout counter cleared on entry.
  - core_done: latch core_result, branch_taken, branch_target; go to SEND_HI.
  - Counter reaching TIMEOUT with no done: error=1, go to IDLE.
  - core_done in the same cycle as the timeout: done wins.
- SEND_HI: tx_valid=1, tx_data=result[15:8]; advance on tx_ready.
- SEND_LO: tx_data=result[7:0]; advance on tx_ready. tx_valid/tx_data stay stable while tx_ready=0.
- After SEND_LO accepts: next_pc = branch_taken ? branch_target : pc+1, computed at ADDR_W+1 bits so pc=MEM_DEPTH-1 does not wrap.
  - next_pc >= instr_count: go to FINISH.
  - Otherwise pc<=next_pc and go to ISSUE.
- FINISH (1 cycle): run_done=1, pc<=0, then IDLE.
- abort in any non-IDLE state: IDLE next cycle, pc=0, tx_valid=0, core_run=0, no run_done. A core_done arriving after abort is ignored.
- error clears only on reset or on a new start.
- Result-to-first-byte latency: core_done at cycle N -> tx_valid high at N+1.

Decomposition:
- Shared package bitty_pkg:
  - sequencer state enum (IDLE, ISSUE, WAIT, SEND_HI, SEND_LO, FINISH)
  - INSTR_W=16 and BYTE_W=8 constants
- One sub-module, bitty_imem: MEM_DEPTH x 16 register file, single write port (we, waddr, wdata), combinational read port. The FSM stays in bitty_sequencer.

Test Plan:
- Load and run. Load bytes 0x12,0x34,0xAB,0xCD, start; core returns 0x0001 then 0xBEEF, no branch. Required: instr_out 0x1234 then 0xABCD; tx bytes 0x00,0x01,0xBE,0xEF; one run_done; pc back to 0.
- Branch back. 3-word program; word 2 returns branch_taken=1, target=0 once, then not taken. Required: issue order 0,1,2,0,1,2; run_done after 6 issues.
- tx backpressure. tx_ready=0 for 10 cycles during SEND_HI. Required: tx_valid=1 and tx_data stable throughout; no second core_run until both bytes are accepted.
- Overflow and timeout.
  - Send 34 bytes with MEM_DEPTH=16. Required: instr_count=16, error=1.
  - Separately, never assert core_done. Required: error=1 exactly TIMEOUT cycles after WAIT entry; state IDLE.
- Abort and reset mid-run.
  - abort during WAIT, then a late core_done. Required: IDLE, no tx_valid, no run_done.
  - Async reset mid-SEND_HI. Required: tx_valid=0 immediately, busy=0.
- Start edge cases.
  - start with an empty program. Required: run_done the next cycle, no core_run.
  - start while load_en=1. Required: ignored.

Source files
------------

// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty program loader / sequencer.
//   INSTR_W     : instruction / result word width
//   BYTE_W      : byte-stream width on the rx and tx sides
//   seq_state_e : sequencer FSM state encoding
package bitty_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4,
    FINISH  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/bitty_imem.sv
// Local instruction memory: DEPTH x INSTR_W register file, no reset.
//   clk     : write clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata_c : combinational read data
module bitty_imem
  import bitty_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata_c
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Single write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/bitty_sequencer.sv
// Program loader and execution sequencer for the bitty core.
//   clk, reset          : clock, async active-high reset
//   load_en, rx_valid,
//   rx_data             : byte stream (high byte first) loading program memory
//   start, abort        : begin execution at pc 0 / stop and return to IDLE
//   instr_out, core_run : instruction and one-cycle execute pulse to the core
//   core_done, core_result,
//   branch_taken, branch_target : core completion and branch outcome
//   tx_valid, tx_data, tx_ready : result byte stream, high byte first
//   busy, run_done, error       : status (error is sticky)
module bitty_sequencer
  import bitty_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic               rx_valid,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               start,
  input  logic               abort,
  output logic [INSTR_W-1:0] instr_out,
  output logic               core_run,
  input  logic               core_done,
  input  logic [INSTR_W-1:0] core_result,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               tx_valid,
  output logic [BYTE_W-1:0]  tx_data,
  input  logic               tx_ready,
  output logic               busy,
  output logic               run_done,
  output logic               error
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  seq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    count_q, count_d, count_base;
  logic                phase_q, phase_d, phase_base;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic                load_en_q;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [INSTR_W-1:0]  result_q, result_d;
  logic                br_taken_q, br_taken_d;
  logic [ADDR_W-1:0]   br_target_q, br_target_d;
  logic [INSTR_W-1:0]  instr_d;
  logic                core_run_d, tx_valid_d, busy_d, run_done_d, error_d;
  logic [BYTE_W-1:0]   tx_data_d;

  logic                we_c;
  logic [ADDR_W-1:0]   waddr_c, raddr_c;
  logic [INSTR_W-1:0]  rdata_c;
  logic [CNT_W-1:0]    next_pc_c;

  bitty_imem #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_imem (
    .clk     (clk),
    .we      (we_c),
    .waddr   (waddr_c),
    .wdata   ({hi_q, rx_data}),
    .raddr   (raddr_c),
    .rdata_c (rdata_c)
  );

  // Next pc is one bit wider so pc = MEM_DEPTH-1 plus one reaches the end
  // instead of wrapping; the read port is pre-addressed with it so ISSUE
  // presents the fetched word from its first cycle.
  always_comb begin
    next_pc_c = br_taken_q ? CNT_W'(br_target_q) : CNT_W'(pc_q) + CNT_W'(1);
    raddr_c   = (state_q == SEND_LO) ? next_pc_c[ADDR_W-1:0] : '0;
  end

  // State register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      count_q     <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      load_en_q   <= 1'b0;
      tmo_q       <= '0;
      result_q    <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      instr_out   <= '0;
      core_run    <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      run_done    <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      load_en_q   <= load_en;
      tmo_q       <= tmo_d;
      result_q    <= result_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      instr_out   <= instr_d;
      core_run    <= core_run_d;
      tx_valid    <= tx_valid_d;
      tx_data     <= tx_data_d;
      busy        <= busy_d;
      run_done    <= run_done_d;
      error       <= error_d;
    end
  end

  // Next-state, loader and output logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    tmo_d       = tmo_q;
    result_d    = result_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    instr_d     = instr_out;
    core_run_d  = 1'b0;
    tx_valid_d  = tx_valid;
    tx_data_d   = tx_data;
    run_done_d  = 1'b0;
    error_d     = error;
    we_c        = 1'b0;
    waddr_c     = '0;
    count_base  = count_q;
    phase_base  = phase_q;

    case (state_q)
      IDLE: begin
        // A fresh load_en starts a new program from word 0
        if (load_en && !load_en_q) begin
          count_base = '0;
          phase_base = 1'b0;
        end
        count_d = count_base;
        phase_d = phase_base;
        if (load_en && rx_valid) begin
          if (count_base == CNT_W'(MEM_DEPTH)) begin
            error_d = 1'b1;
          end else if (!phase_base) begin
            hi_d    = rx_data;
            phase_d = 1'b1;
          end else begin
            we_c    = 1'b1;
            waddr_c = count_base[ADDR_W-1:0];
            count_d = count_base + CNT_W'(1);
            phase_d = 1'b0;
          end
        end else if (start && !load_en) begin
          error_d = 1'b0;
          pc_d    = '0;
          if (count_q == '0) begin
            run_done_d = 1'b1;
          end else begin
            state_d    = ISSUE;
            core_run_d = 1'b1;
            instr_d    = rdata_c;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        tmo_d   = '0;
      end
      WAIT: begin
        if (core_done) begin
          result_d    = core_result;
          br_taken_d  = branch_taken;
          br_target_d = branch_target;
          state_d     = SEND_HI;
          tx_valid_d  = 1'b1;
          tx_data_d   = core_result[INSTR_W-1 -: BYTE_W];
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          pc_d    = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      SEND_HI: begin
        if (tx_ready) begin
          state_d   = SEND_LO;
          tx_data_d = result_q[BYTE_W-1:0];
        end
      end
      SEND_LO: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (next_pc_c >= count_q) begin
            state_d    = FINISH;
            run_done_d = 1'b1;
            pc_d       = '0;
          end else begin
            pc_d       = next_pc_c[ADDR_W-1:0];
            state_d    = ISSUE;
            core_run_d = 1'b1;
            instr_d    = rdata_c;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      pc_d       = '0;
      tx_valid_d = 1'b0;
      core_run_d = 1'b0;
      run_done_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_bitty_sequencer.sv
// Self-checking bench for bitty_sequencer: a behavioural program-walk model
// predicts issue order and tx byte stream; a core/transmitter responder
// drives randomized latencies and backpressure.
module tb_bitty_sequencer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned TMO   = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_en = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   instr_out;
  logic          core_run;
  logic          core_done = 1'b0;
  logic [15:0]   core_result = '0;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic          run_done;
  logic          error;

  int checks = 0;
  int errors = 0;

  logic [15:0]   prog[$];
  logic [15:0]   res_tab[64];
  bit            tk_tab[64];
  logic [AW-1:0] tg_tab[64];
  logic [15:0]   iss_q[$];
  logic [15:0]   exp_i_q[$];
  logic [7:0]    txb_q[$];
  logic [7:0]    exp_b_q[$];
  int            rd_cnt;
  int            viol;

  bitty_sequencer #(
    .MEM_DEPTH (DEPTH),
    .ADDR_W    (AW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .start         (start),
    .abort         (abort),
    .instr_out     (instr_out),
    .core_run      (core_run),
    .core_done     (core_done),
    .core_result   (core_result),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .run_done      (run_done),
    .error         (error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tabs();
    for (int k = 0; k < 64; k++) begin
      res_tab[k] = 16'($urandom);
      tk_tab[k]  = 1'b0;
      tg_tab[k]  = '0;
    end
  endtask

  // Reference: walk the program by the branch rules, one result per issue
  task automatic model_run();
    int n, pc, k, nx;
    n = (prog.size() > DEPTH) ? DEPTH : prog.size();
    exp_i_q.delete();
    exp_b_q.delete();
    pc = 0;
    k  = 0;
    while (n > 0 && k < 64) begin
      exp_i_q.push_back(prog[pc]);
      exp_b_q.push_back(res_tab[k][15:8]);
      exp_b_q.push_back(res_tab[k][7:0]);
      nx = tk_tab[k] ? int'(tg_tab[k]) : pc + 1;
      k++;
      if (nx >= n) break;
      pc = nx;
    end
  endtask

  function automatic int bad_words();
    int b = 0;
    if (iss_q.size() != exp_i_q.size()) b++;
    foreach (exp_i_q[i]) if (i >= iss_q.size() || iss_q[i] !== exp_i_q[i]) b++;
    return b;
  endfunction

  function automatic int bad_bytes();
    int b = 0;
    if (txb_q.size() != exp_b_q.size()) b++;
    foreach (exp_b_q[i]) if (i >= txb_q.size() || txb_q[i] !== exp_b_q[i]) b++;
    return b;
  endfunction

  task automatic load_prog();
    load_en = 1'b0;
    tick();
    load_en = 1'b1;
    tick();
    foreach (prog[i]) begin
      rx_valid = 1'b1;
      rx_data  = prog[i][15:8];
      tick();
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      rx_valid = 1'b1;
      rx_data  = prog[i][7:0];
      tick();
      rx_valid = 1'b0;
    end
    load_en = 1'b0;
    tick();
  endtask

  // Pulse start, then act as core and transmitter until run_done (bounded)
  task automatic run_prog(input int budget, input bit rand_ready, input int hold);
    int lat, since, cur, k, tail;
    bit pend, prev_stall, expect_tx, prev_run;
    logic [7:0] prev_data;
    logic [15:0] sent;
    iss_q.delete();
    txb_q.delete();
    rd_cnt = 0; viol = 0; k = 0; cur = 0; lat = 0; since = 2; tail = -1;
    pend = 0; prev_stall = 0; expect_tx = 0; prev_run = 0; prev_data = '0; sent = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < budget && tail != 0; cyc++) begin
      core_done    = 1'b0;
      branch_taken = 1'b0;
      if (expect_tx && (tx_valid !== 1'b1 || tx_data !== sent[15:8])) viol++;
      expect_tx = 0;
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) viol++;
      if (pend) begin
        if (lat == 0) begin
          core_done     = 1'b1;
          core_result   = res_tab[cur];
          branch_taken  = tk_tab[cur];
          branch_target = tg_tab[cur];
          sent          = res_tab[cur];
          pend          = 0;
          expect_tx     = 1;
        end else begin
          lat--;
        end
      end
      if (core_run === 1'b1) begin
        if (prev_run || since < 2) viol++;
        iss_q.push_back(instr_out);
        cur   = (k < 64) ? k : 63;
        k++;
        pend  = 1;
        lat   = $urandom_range(0, 3);
        since = 0;
      end
      prev_run = (core_run === 1'b1);
      if (tx_valid === 1'b1 && hold > 0) begin
        tx_ready = 1'b0;
        hold--;
      end else begin
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (tx_valid === 1'b1 && tx_ready) begin
        txb_q.push_back(tx_data);
        since++;
      end
      prev_stall = (tx_valid === 1'b1) && !tx_ready;
      prev_data  = tx_data;
      if (run_done === 1'b1) begin
        rd_cnt++;
        if (tail < 0) tail = 4;
      end
      if (tail > 0) tail--;
      tick();
    end
    core_done = 1'b0;
    tx_ready  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (instr_out !== 16'h0000) begin
      errors++; $display("FAIL reset instr_out: got %h want 0000", instr_out);
    end
    checks++;
    if ({tx_valid, tx_data} !== 9'h000) begin
      errors++; $display("FAIL reset tx: got valid=%b data=%h want 0/00", tx_valid, tx_data);
    end
    checks++;
    if ({core_run, run_done, error, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset flags: got run=%b done=%b err=%b busy=%b want 0000",
                         core_run, run_done, error, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_empty_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({run_done, core_run, busy} !== 3'b100) begin
      errors++; $display("FAIL empty_start: got done=%b run=%b busy=%b want 1 0 0", run_done, core_run, busy);
    end
    tick();
    checks++;
    if ({run_done, core_run} !== 2'b00) begin
      errors++; $display("FAIL empty_start pulse: got done=%b run=%b want 0 0", run_done, core_run);
    end
  endtask

  task automatic check_run(input string tag);
    model_run();
    checks++;
    if (bad_words() != 0) begin
      errors++; $display("FAIL %s issue_seq: got %0d words (%0d bad) want %0d words",
                         tag, iss_q.size(), bad_words(), exp_i_q.size());
    end
    checks++;
    if (bad_bytes() != 0) begin
      errors++; $display("FAIL %s tx_bytes: got %0d bytes (%0d bad) want %0d bytes",
                         tag, txb_q.size(), bad_bytes(), exp_b_q.size());
    end
    checks++;
    if (rd_cnt != 1) begin
      errors++; $display("FAIL %s run_done_count: got %0d want 1", tag, rd_cnt);
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL %s protocol: got %0d violations want 0", tag, viol);
    end
  endtask

  task automatic test_load_run();
    prog = '{16'h1234, 16'hABCD};
    clear_tabs();
    res_tab[0] = 16'h0001;
    res_tab[1] = 16'hBEEF;
    load_prog();
    run_prog(200, 1'b0, 0);
    check_run("load_run");
    checks++;
    if ({instr_out, busy, error} !== {16'hABCD, 2'b00}) begin
      errors++; $display("FAIL load_run idle_state: got instr=%h busy=%b err=%b want abcd 0 0",
                         instr_out, busy, error);
    end
  endtask

  task automatic test_back_to_back();
    clear_tabs();
    run_prog(200, 1'b1, 0);
    check_run("back_to_back");
  endtask

  task automatic test_branch_back();
    prog = '{16'($urandom), 16'($urandom), 16'($urandom)};
    clear_tabs();
    tk_tab[2] = 1'b1;
    tg_tab[2] = '0;
    load_prog();
    run_prog(400, 1'b1, 0);
    check_run("branch_back");
    checks++;
    if (iss_q.size() != 6) begin
      errors++; $display("FAIL branch_back issue_count: got %0d want 6", iss_q.size());
    end
  endtask

  task automatic test_backpressure();
    prog = '{16'h1111, 16'h2222};
    clear_tabs();
    load_prog();
    run_prog(300, 1'b0, 10);
    check_run("backpressure");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      prog.delete();
      repeat ($urandom_range(1, 8)) prog.push_back(16'($urandom));
      clear_tabs();
      for (int k = 0; k < 4; k++) begin
        tk_tab[k] = ($urandom_range(0, 3) == 0);
        tg_tab[k] = AW'($urandom_range(0, 15));
      end
      load_prog();
      run_prog(2000, 1'b1, 0);
      check_run("random");
    end
  endtask

  task automatic test_overflow();
    logic [15:0] wd;
    prog.delete();
    repeat (17) prog.push_back(16'($urandom));
    clear_tabs();
    load_en = 1'b0;
    tick();
    load_en = 1'b1;
    tick();
    for (int b = 0; b < 34; b++) begin
      wd = prog[b / 2];
      rx_valid = 1'b1;
      rx_data  = (b % 2 == 0) ? wd[15:8] : wd[7:0];
      tick();
      rx_valid = 1'b0;
      if (b == 31) begin
        checks++;
        if (error !== 1'b0) begin
          errors++; $display("FAIL overflow early_error: got %b want 0", error);
        end
      end
      if (b == 32) begin
        checks++;
        if (error !== 1'b1) begin
          errors++; $display("FAIL overflow error: got %b want 1", error);
        end
      end
    end
    load_en = 1'b0;
    tick();
    run_prog(1000, 1'b0, 0);
    check_run("overflow");
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL overflow error_clear_on_start: got %b want 0", error);
    end
  endtask

  task automatic wait_core_run(input string tag);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      if (core_run === 1'b1) begin
        found = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL %s core_run: got none within 20 cycles want pulse", tag);
    end
  endtask

  task automatic test_timeout();
    prog = '{16'h0F0F};
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_core_run("timeout");
    repeat (TMO) tick();
    checks++;
    if ({error, busy} !== 2'b01) begin
      errors++; $display("FAIL timeout early: got err=%b busy=%b want 0 1", error, busy);
    end
    tick();
    checks++;
    if ({error, busy, tx_valid} !== 3'b100) begin
      errors++; $display("FAIL timeout flag: got err=%b busy=%b txv=%b want 1 0 0", error, busy, tx_valid);
    end
  endtask

  task automatic test_abort();
    int bad = 0;
    prog = '{16'hA0A0, 16'hB0B0};
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_core_run("abort");
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, tx_valid, core_run} !== 3'b000) begin
      errors++; $display("FAIL abort idle: got busy=%b txv=%b run=%b want 000", busy, tx_valid, core_run);
    end
    core_done   = 1'b1;
    core_result = 16'h7E57;
    tx_ready    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      core_done = 1'b0;
      if (tx_valid !== 1'b0 || run_done !== 1'b0 || core_run !== 1'b0 || busy !== 1'b0) bad++;
    end
    tx_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL abort late_done: got %0d active cycles want 0", bad);
    end
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL abort error: got %b want 0", error);
    end
  endtask

  task automatic test_start_while_loading();
    int bad = 0;
    load_en = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (core_run !== 1'b0 || busy !== 1'b0 || run_done !== 1'b0) bad++;
      tick();
    end
    load_en = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL start_while_loading: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid_send();
    prog = '{16'h4242};
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_core_run("reset_mid_send");
    tick();
    core_done   = 1'b1;
    core_result = 16'h5AA5;
    tx_ready    = 1'b0;
    tick();
    core_done = 1'b0;
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL send_hi latency: got txv=%b data=%h want 1 5a", tx_valid, tx_data);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({tx_valid, busy, tx_data} !== 10'h000) begin
      errors++; $display("FAIL reset_mid_send: got txv=%b busy=%b data=%h want 0 0 00", tx_valid, busy, tx_data);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_empty_start();
    test_load_run();
    test_back_to_back();
    test_branch_back();
    test_backpressure();
    test_random();
    test_overflow();
    test_timeout();
    test_abort();
    test_start_while_loading();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
